// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver, with a valid/ready pop port,
// fill level and sticky overflow. Optional macro UART_RX_FIFO_DROP_BAD_EN discards parity-bad bytes.
module uart_rx_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ERR_CNT_BITS = 8
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     in_en,
    input  logic [7:0]               in_data,
    input  logic                     in_parity_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_parity_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic [ERR_CNT_BITS-1:0]  drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
`ifdef UART_RX_FIFO_DROP_BAD_EN
    localparam int unsigned EW = 8;
`else
    localparam int unsigned EW = 9;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [EW-1:0] wr_entry;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] level_nxt;
    logic          valid_nxt;
    logic          overflow_nxt;
    logic          in_ok;
    logic          full;
    logic          push;
    logic          pop;
    logic          ovf_hit;

    // Next-state for pointers, level, valid and overflow
    always_comb begin
        in_ok        = in_en;
`ifdef UART_RX_FIFO_DROP_BAD_EN
        in_ok        = in_en & in_parity_valid;
`endif
        full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop          = out_valid & out_ready;
        push         = in_ok & (~full | pop);
        ovf_hit      = in_ok & full & ~pop;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        level_nxt    = level;
        overflow_nxt = overflow;

        if (push) begin
            wr_ptr_nxt = wr_ptr + PW'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
        end

        case ({push, pop})
            2'b10:   level_nxt = level + PW'(1);
            2'b01:   level_nxt = level - PW'(1);
            default: level_nxt = level;
        endcase

        // A new overflow on the same edge as a clear request keeps the flag set
        if (ovf_hit) begin
            overflow_nxt = 1'b1;
        end else if (clr_overflow) begin
            overflow_nxt = 1'b0;
        end

        valid_nxt = (wr_ptr_nxt != rd_ptr_nxt);
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            out_valid <= valid_nxt;
            overflow  <= overflow_nxt;
        end
    end

    // Storage array is intentionally not reset
`ifdef UART_RX_FIFO_DROP_BAD_EN
    assign wr_entry = in_data;
`else
    assign wr_entry = {in_parity_valid, in_data};
`endif

    always_ff @(posedge clk) begin
        if (nRst && push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // Head entry is presented straight from the array (first-word fall-through)
    assign head     = mem[rd_ptr[AW-1:0]];
    assign out_data = head[7:0];

`ifdef UART_RX_FIFO_DROP_BAD_EN
    logic [ERR_CNT_BITS-1:0] drop_q;

    assign out_parity_err = 1'b0;
    assign drop_cnt       = drop_q;

    // Saturating count of discarded parity-bad bytes
    always_ff @(posedge clk) begin
        if (!nRst) begin
            drop_q <= '0;
        end else if (in_en && !in_parity_valid && (drop_q != {ERR_CNT_BITS{1'b1}})) begin
            drop_q <= drop_q + ERR_CNT_BITS'(1);
        end
    end
`else
    assign out_parity_err = ~head[8];
    assign drop_cnt       = '0;
`endif

endmodule
